// File: rtl/halfband_dec2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | halfband_dec2 : decimate-by-2 15-tap half-band FIR behind the CIC,  |
// |                 one time-shared multiplier.   Revision 1.0         |
// +--------------------------------------------------------------------+
module halfband_dec2 #(
  parameter int IN_W   = 19,
  parameter int OFFSET = 131072,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in,
  input  logic            in_valid,
  output logic [IN_W-1:0] out,
  output logic            out_valid,
  output logic            busy,
  output logic            ovf
);

  localparam int c_taps   = 15;
  localparam int c_pre_w  = IN_W + 1;
  localparam int c_prod_w = c_pre_w + COEF_W;
  localparam int c_acc_w  = c_prod_w + 3;
  localparam logic [IN_W-1:0]           c_offset = IN_W'(OFFSET);
  localparam logic signed [c_acc_w-1:0] c_round  = c_acc_w'(2 ** (SHIFT - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [2:0]                 r_k;
  logic signed [c_acc_w-1:0]  r_acc;
  logic signed [IN_W-1:0]     r_dly [c_taps];
  logic                       r_phase;
  logic signed [IN_W-1:0]     r_hold;
  logic                       r_hold_full;

  logic signed [IN_W-1:0]     w_x;
  logic                       w_idle;
  logic                       w_shift;
  logic signed [IN_W-1:0]     w_shift_x;
  logic                       w_trigger;
  logic [3:0]                 w_idx_a;
  logic [3:0]                 w_idx_b;
  logic signed [IN_W-1:0]     w_tap_a;
  logic signed [IN_W-1:0]     w_tap_b;
  logic signed [c_pre_w-1:0]  w_pre;
  logic signed [COEF_W-1:0]   w_coef;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_acc_w-1:0]  w_acc_sum;
  logic [IN_W-1:0]            w_out;

  assign w_x       = $signed(in - c_offset);
  assign w_idle    = (r_state == ST_IDLE);
  // A parked sample takes priority over a fresh strobe when the engine frees up.
  assign w_shift   = w_idle & (r_hold_full | in_valid);
  assign w_shift_x = r_hold_full ? r_hold : w_x;
  assign w_trigger = w_shift & r_phase;

  assign w_idx_a = {1'b0, r_k};
  assign w_idx_b = 4'd14 - w_idx_a;
  assign w_tap_a = r_dly[w_idx_a];
  assign w_tap_b = (r_k == 3'd7) ? '0 : r_dly[w_idx_b];
  assign w_pre   = {w_tap_a[IN_W-1], w_tap_a} + {w_tap_b[IN_W-1], w_tap_b};

  always_comb begin
    w_coef = '0;
    case (r_k)
      3'd0:    w_coef = COEF_W'(-64);
      3'd2:    w_coef = COEF_W'(300);
      3'd4:    w_coef = COEF_W'(-1100);
      3'd6:    w_coef = COEF_W'(9056);
      3'd7:    w_coef = COEF_W'(16384);
      default: w_coef = '0;
    endcase
  end

  assign w_prod    = w_pre * w_coef;
  assign w_acc_sum = r_acc + {{(c_acc_w - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
  assign w_out     = IN_W'((r_acc + c_round) >>> SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_phase     <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      out         <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
      for (int i = 0; i < c_taps; i++) r_dly[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      busy      <= !w_idle;

      if (w_shift) begin
        r_dly[0] <= w_shift_x;
        for (int i = 1; i < c_taps; i++) r_dly[i] <= r_dly[i-1];
        r_phase <= ~r_phase;
      end

      if (in_valid && (!w_idle || r_hold_full)) begin
        if (!w_idle && r_hold_full) begin
          ovf <= 1'b1;
        end else begin
          r_hold      <= w_x;
          r_hold_full <= 1'b1;
        end
      end else if (w_idle && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state <= ST_MAC;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= ST_OUT;
        end
        ST_OUT: begin
          out       <= w_out;
          out_valid <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_halfband_dec2.sv
`default_nettype none
// tb_halfband_dec2: directed and random stimulus checked every cycle against a
// timestamped convolution model of the decimating half-band filter.
module tb_halfband_dec2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] in = '0;
  logic [18:0] out;
  logic        out_valid;
  logic        busy;
  logic        ovf;

  halfband_dec2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int h [15] = '{-64, 0, 300, 0, -1100, 0, 9056, 16384, 9056, 0, -1100, 0, 300, 0, -64};

  // Model state: sample history plus timestamps of the pending output.
  int cyc = 0;
  int hist [15];
  bit phase = 1'b0;
  bit hold_v = 1'b0;
  int hold_x = 0;
  bit m_ovf = 1'b0;
  int m_out = 0;
  int m_pending = 0;
  int out_at = -1;
  int free_at = 0;
  int busy_from = 1;
  int busy_to = 0;
  int outs [$];

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int conv();
    longint s = 0;
    for (int k = 0; k < 15; k++) s += longint'(h[k]) * longint'(hist[k]);
    return int'((s + 64'sd16384) >>> 15);
  endfunction

  always @(posedge clk) begin
    int x;
    int sx;
    bit have;
    cyc++;
    x = int'(in) - 131072;
    if (!rst_n) begin
      for (int k = 0; k < 15; k++) hist[k] = 0;
      phase = 1'b0; hold_v = 1'b0; m_ovf = 1'b0; m_out = 0;
      out_at = -1; free_at = 0; busy_from = 1; busy_to = 0;
    end else begin
      if (cyc == out_at) m_out = m_pending;
      if (cyc < free_at) begin
        if (in_valid) begin
          if (!hold_v) begin hold_v = 1'b1; hold_x = x; end
          else m_ovf = 1'b1;
        end
      end else begin
        have = 1'b0;
        sx = 0;
        if (hold_v) begin
          sx = hold_x; have = 1'b1;
          if (in_valid) hold_x = x; else hold_v = 1'b0;
        end else if (in_valid) begin
          sx = x; have = 1'b1;
        end
        if (have) begin
          for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = sx;
          if (phase) begin
            m_pending = conv();
            out_at    = cyc + 9;
            free_at   = cyc + 10;
            busy_from = cyc + 1;
            busy_to   = cyc + 9;
          end
          phase = !phase;
        end
      end
    end
    #1;
    check("out", $signed(out), m_out);
    check("out_valid", out_valid, cyc == out_at);
    check("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
    check("ovf", ovf, m_ovf);
    if (out_valid) outs.push_back(int'($signed(out)));
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    in = 19'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    outs.delete();
  endtask

  task automatic check_outs(input string name, input int exp[$]);
    check("outs_count", outs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outs.size(); i++) check(name, outs[i], exp[i]);
  endtask

  initial begin
    int e[$];
    int lat;
    int bc;

    gap(3);
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    rst_n = 1'b1;

    // DC: x = 1000 settles to 1000 once the line is full
    outs.delete();
    for (int i = 0; i < 20; i++) begin
      send(132072);
      if (i == 0) check("dc_pre_trigger_out", $signed(out), 0);
      gap(62);
    end
    check("dc_count", outs.size(), 10);
    for (int i = 7; i < 10 && i < outs.size(); i++) check("dc_settled", outs[i], 1000);

    // impulse on the trigger phase walks the even taps
    do_reset();
    for (int i = 0; i < 18; i++) begin send(i == 1 ? 163840 : 131072); gap(62); end
    e = '{-64, 300, -1100, 9056, 9056, -1100, 300, -64, 0};
    check_outs("imp_trig", e);

    // impulse on the non-trigger phase only meets the centre tap
    do_reset();
    for (int i = 0; i < 16; i++) begin send(i == 0 ? 163840 : 131072); gap(62); end
    e = '{0, 0, 0, 16384, 0, 0, 0, 0};
    check_outs("imp_nontrig", e);

    // overrun: E3 sample parks in hold, E5 sample is dropped
    do_reset();
    send(131072); gap(62);
    @(negedge clk); in = 19'd131072; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); in = 19'd163840; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("ovf_after_E3", ovf, 0);
    @(negedge clk); in = 19'd98304; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("ovf_after_E5", ovf, 1);
    gap(58);
    for (int i = 0; i < 9; i++) begin send(131072); gap(62); end
    e = '{0, 0, 0, 0, 16384, 0};
    check_outs("overrun", e);
    check("ovf_sticky", ovf, 1);

    // latency and busy width
    do_reset();
    send(132072); gap(62);
    @(negedge clk); in = 19'd132072; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    lat = -1;
    bc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (busy) bc++;
      if (out_valid && lat < 0) lat = i;
    end
    check("latency", lat, 9);
    check("busy_cycles", bc, 9);
    check("first_dc_out", $signed(out), -2);
    gap(40);

    // reset mid-MAC
    send(132072); gap(62);
    @(negedge clk); in = 19'd132072; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ovf", ovf, 0);
    gap(3);
    rst_n = 1'b1;
    outs.delete();
    send(132072); gap(62);
    check("post_reset_count1", outs.size(), 0);
    send(132072); gap(62);
    check("post_reset_count2", outs.size(), 1);

    // random traffic, first relaxed then heavy enough to overrun
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(int'($urandom_range(0, 262144)));
      gap(int'($urandom_range(3, 20)));
    end
    for (int i = 0; i < 200; i++) begin
      send(int'($urandom_range(0, 262144)));
      gap(int'($urandom_range(0, 12)));
    end
    gap(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
